bcrypt_core_sched: RTL and testbench
====================================

// Module: bcrypt_core_sched
// PURPOSE
//  Sequences and shares the host BRAM port between NUM_CORES bcrypt loop cores.
//  Drives each core's 32-bit start code: 0=clear, 1=load, 2=compute, 3=store.
//  Reads each core's 32-bit done code: 1=loaded, 2=computed, 0xFF=stored.
//  Load and store run one core at a time, because the BRAM port is shared.
//  Compute runs on all cores in parallel. Reports busy/finished/error to the host register file.
// PARAMETERS
//  NUM_CORES      4        number of cores scheduled (1..16)
//  SEL_W          4        width of grant_sel; must satisfy 2**SEL_W >= NUM_CORES
//  CLR_CYCLES     4        cycles start=0 is held on all cores before loading
//  TIMEOUT        2**24    watchdog limit, in cycles, per wait (per core in LOAD/STORE)
// PORTS
//  clk          in   1              system clock; all logic on rising edge
//  rst          in   1              synchronous, active-high reset
//  go           in   1              one-cycle pulse from host: start a full run
//  busy         out  1              high from accepted go until DONE or ERROR
//  finished     out  1              high in DONE; held until next go or rst
//  error        out  1              high in ERROR; held until next go or rst
//  err_core     out  SEL_W          core index being waited on at timeout
//  core_start   out  32*NUM_CORES   start code per core; core i = [32*i+31:32*i]
//  core_done    in   32*NUM_CORES   done code per core, same packing
//  grant_valid  out  1              high while a core owns the BRAM port
//  grant_sel    out  SEL_W          BRAM mux select; valid only when grant_valid=1
// BEHAVIOUR
//  Reset values (next edge after rst=1): core_start all 0, busy=0, finished=0, error=0,
//   grant_valid=0, grant_sel=0, err_core=0, state=IDLE, all counters 0.
//  All outputs are registered. core_done is sampled through one register stage (done_q).
//  FSM states and transitions:
//  - IDLE: go=1 -> CLEAR. Also clears finished and error; busy=1 from the next cycle.
//  - CLEAR: all start=0 for CLR_CYCLES cycles; then k=0 -> LOAD.
//  - LOAD: start[k]=1, grant_valid=1, grant_sel=k.
//    - Cores < k hold 1; cores > k hold 0.
//    - done_q[k]==1 -> grant_valid=0 for 1 cycle.
//    - Then k++, or k==NUM_CORES-1 -> COMPUTE.
//  - COMPUTE: all start=2, grant_valid=0. All done_q[i]==2 -> k=0 -> STORE.
//  - STORE: start[k]=3, grant_valid=1, grant_sel=k.
//    - Cores < k hold 3; cores > k hold 2.
//    - done_q[k]==0xFF -> 1 idle cycle, then k++, or last core -> DONE.
//  - DONE: busy=0, finished=1, grant_valid=0. Start codes hold 3.
//    - go=1 -> CLEAR; finished drops in the same cycle busy rises.
//  - ERROR: all start=0, busy=0, error=1, grant_valid=0.
//    - err_core = k (LOAD/STORE), or the lowest core not yet done (COMPUTE).
//    - go=1 -> CLEAR.
//  Watchdog:
//   - 25-bit counter, zeroed on every state entry and every k advance.
//   - Increments each cycle in LOAD/COMPUTE/STORE.
//   - Reaching TIMEOUT -> ERROR on the next edge.
//  Handshake: a done code counts only when it matches the current phase's code.
//   - Stale codes are ignored (e.g. done=1 seen in COMPUTE, done=2 seen in STORE).
//  Grant: never two cores granted at once. grant_sel changes only while grant_valid=0
//   (one-cycle gap between owners).
//  go while busy=1: ignored, no effect.
//  Done match and timeout in the same cycle: the done match wins (no ERROR).
//  rst mid-run: next edge all start=0 and grant_valid=0. Cores self-clear on start=0.
//  NUM_CORES=1: LOAD and STORE each run once; k wrap logic must not index out of range.
// TESTING
//  - T1 reset: rst=1 for 2 cycles mid-COMPUTE -> core_start=0, busy=0, grant_valid=0
//    the cycle after.
//  - T2 run: NUM_CORES=2, bench cores answer load in 10, compute in 50, store in 20 cycles.
//    Required order:
//    - start[0]=1 grant 0
//    - start[1]=1 grant 1
//    - both 2, no grant
//    - start[0]=3 grant 0
//    - start[1]=3 grant 1
//    - finished=1
//  - T3 grant: check in every cycle that at most one core is granted and that
//    grant_sel never changes while grant_valid=1.
//  - T4 timeout: TIMEOUT=100, core 1 never reports done=2 -> error=1, err_core=1,
//    all start=0 at cycle 100 of COMPUTE.
//    Then go -> error=0 and a full run completes.
//  - T5 edge cases:
//    - go while busy -> no restart; the run completes once.
//    - done=1 held high during COMPUTE -> no early STORE.
//    - done and timeout on the same cycle -> no ERROR.

Source files
------------

// File: rtl/bcrypt_core_sched.sv
// bcrypt_core_sched
//   Schedules NUM_CORES bcrypt loop cores that share one host BRAM port.
//   A run is: clear all cores, load them one at a time, compute on all of
//   them in parallel, store them one at a time, then report to the host.
//   Every wait on a core is bounded by a watchdog. A timeout parks all cores
//   in the clear code and raises error.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   go           one-cycle host pulse that starts a run; ignored while busy
//   busy         run in progress
//   finished     last run completed; held until next go or rst
//   error        last run timed out; held until next go or rst
//   err_core     core that was being waited on when the watchdog fired
//   core_start   per-core 32-bit start code (0 clear, 1 load, 2 compute, 3 store)
//   core_done    per-core 32-bit done code (1 loaded, 2 computed, 0xFF stored)
//   grant_valid  a core owns the BRAM port
//   grant_sel    BRAM mux select, meaningful only while grant_valid=1

module bcrypt_core_sched #(
  parameter int NUM_CORES  = 4,
  parameter int SEL_W      = 4,
  parameter int CLR_CYCLES = 4,
  parameter int TIMEOUT    = 2**24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  output logic                    busy,
  output logic                    finished,
  output logic                    error,
  output logic [SEL_W-1:0]        err_core,
  output logic [32*NUM_CORES-1:0] core_start,
  input  logic [32*NUM_CORES-1:0] core_done,
  output logic                    grant_valid,
  output logic [SEL_W-1:0]        grant_sel
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_COMP  = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  localparam logic [SEL_W-1:0] LAST_K     = SEL_W'(NUM_CORES - 1);
  localparam logic [15:0]      CLR_LAST   = 16'(CLR_CYCLES - 1);
  localparam logic [24:0]      WD_LAST    = 25'(TIMEOUT - 1);
  localparam logic [31:0]      CODE_CLEAR = 32'd0;
  localparam logic [31:0]      CODE_LOAD  = 32'd1;
  localparam logic [31:0]      CODE_COMP  = 32'd2;
  localparam logic [31:0]      CODE_STORE = 32'd3;
  localparam logic [31:0]      DONE_LOAD  = 32'd1;
  localparam logic [31:0]      DONE_COMP  = 32'd2;
  localparam logic [31:0]      DONE_STORE = 32'h0000_00FF;

  state_t                  state_r, state_s;
  logic [SEL_W-1:0]        k_r, k_s;
  logic                    gap_r, gap_s;       // one idle cycle between BRAM owners
  logic [24:0]             wd_r, wd_s;
  logic [15:0]             clr_r, clr_s;
  logic [32*NUM_CORES-1:0] done_q_r;
  logic [31:0]             cur_done_s;
  logic                    all_comp_s;
  logic [SEL_W-1:0]        first_pend_s;
  logic                    wd_hit_s;
  logic                    hit_s;
  logic                    busy_s, finished_s, error_s, grant_valid_s;
  logic [SEL_W-1:0]        err_core_s, grant_sel_s;
  logic [32*NUM_CORES-1:0] core_start_s;

  // Start code of every core for a given state and current core index.
  // Cores below k already passed this phase, cores above k have not yet.
  function automatic logic [32*NUM_CORES-1:0] start_codes(input state_t st,
                                                          input logic [SEL_W-1:0] k);
    logic [32*NUM_CORES-1:0] v;
    v = {(32*NUM_CORES){1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      case (st)
        S_LOAD:  v[32*i +: 32] = (SEL_W'(i) <= k) ? CODE_LOAD : CODE_CLEAR;
        S_COMP:  v[32*i +: 32] = CODE_COMP;
        S_STORE: v[32*i +: 32] = (SEL_W'(i) <= k) ? CODE_STORE : CODE_COMP;
        S_DONE:  v[32*i +: 32] = CODE_STORE;
        default: v[32*i +: 32] = CODE_CLEAR;
      endcase
    end
    return v;
  endfunction

  // Select the current core's sampled done code and summarise compute progress.
  // The descending scan leaves the lowest still-pending core in first_pend_s.
  always_comb begin
    cur_done_s   = 32'd0;
    all_comp_s   = 1'b1;
    first_pend_s = {SEL_W{1'b0}};
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      cur_done_s   = (k_r == SEL_W'(i)) ? done_q_r[32*i +: 32] : cur_done_s;
      all_comp_s   = all_comp_s & (done_q_r[32*i +: 32] == DONE_COMP);
      first_pend_s = (done_q_r[32*i +: 32] != DONE_COMP) ? SEL_W'(i) : first_pend_s;
    end
  end

  // Only the code of the active phase counts; stale codes never match.
  assign hit_s    = (state_r == S_LOAD) ? (cur_done_s == DONE_LOAD) : (cur_done_s == DONE_STORE);
  assign wd_hit_s = (wd_r == WD_LAST);

  // Next-state, core index, watchdog and status decisions.
  always_comb begin
    state_s    = state_r;
    k_s        = k_r;
    gap_s      = gap_r;
    wd_s       = wd_r;
    clr_s      = clr_r;
    finished_s = finished;
    error_s    = error;
    err_core_s = err_core;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          state_s    = S_CLEAR;
          clr_s      = 16'd0;
          finished_s = 1'b0;
          error_s    = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      S_CLEAR: begin
        if (clr_r == CLR_LAST) begin
          state_s = S_LOAD;
          k_s     = {SEL_W{1'b0}};
          gap_s   = 1'b0;
          wd_s    = 25'd0;
          clr_s   = 16'd0;
        end else begin
          clr_s = clr_r + 16'd1;
        end
      end
      S_LOAD, S_STORE: begin
        if (gap_r) begin
          gap_s = 1'b0;
          wd_s  = 25'd0;
          if (k_r == LAST_K) begin
            k_s = {SEL_W{1'b0}};
            if (state_r == S_LOAD) begin
              state_s = S_COMP;
            end else begin
              state_s    = S_DONE;
              finished_s = 1'b1;
            end
          end else begin
            k_s = k_r + SEL_W'(1);
          end
        end else if (hit_s) begin
          // A match on the last watchdog cycle still wins over the timeout.
          gap_s = 1'b1;
          wd_s  = 25'd0;
        end else if (wd_hit_s) begin
          state_s    = S_ERROR;
          error_s    = 1'b1;
          err_core_s = k_r;
          wd_s       = 25'd0;
        end else begin
          wd_s = wd_r + 25'd1;
        end
      end
      S_COMP: begin
        if (all_comp_s) begin
          state_s = S_STORE;
          k_s     = {SEL_W{1'b0}};
          gap_s   = 1'b0;
          wd_s    = 25'd0;
        end else if (wd_hit_s) begin
          state_s    = S_ERROR;
          error_s    = 1'b1;
          err_core_s = first_pend_s;
          wd_s       = 25'd0;
        end else begin
          wd_s = wd_r + 25'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so that
  // every output leaves a flop. grant_sel only moves when a grant begins.
  always_comb begin
    case (state_s)
      S_CLEAR, S_LOAD, S_COMP, S_STORE: busy_s = 1'b1;
      default:                          busy_s = 1'b0;
    endcase
    grant_valid_s = ((state_s == S_LOAD) || (state_s == S_STORE)) && !gap_s;
    if (grant_valid_s) begin
      grant_sel_s = k_s;
    end else begin
      grant_sel_s = grant_sel;
    end
    core_start_s = start_codes(state_s, k_s);
  end

  // State, counters, done sampling stage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      k_r         <= {SEL_W{1'b0}};
      gap_r       <= 1'b0;
      wd_r        <= 25'd0;
      clr_r       <= 16'd0;
      done_q_r    <= {(32*NUM_CORES){1'b0}};
      busy        <= 1'b0;
      finished    <= 1'b0;
      error       <= 1'b0;
      err_core    <= {SEL_W{1'b0}};
      core_start  <= {(32*NUM_CORES){1'b0}};
      grant_valid <= 1'b0;
      grant_sel   <= {SEL_W{1'b0}};
    end else begin
      state_r     <= state_s;
      k_r         <= k_s;
      gap_r       <= gap_s;
      wd_r        <= wd_s;
      clr_r       <= clr_s;
      done_q_r    <= core_done;
      busy        <= busy_s;
      finished    <= finished_s;
      error       <= error_s;
      err_core    <= err_core_s;
      core_start  <= core_start_s;
      grant_valid <= grant_valid_s;
      grant_sel   <= grant_sel_s;
    end
  end

endmodule

// File: tb/tb_bcrypt_core_sched.sv
// tb_bcrypt_core_sched
//   Drives bcrypt_core_sched with behavioural cores whose answer latencies are
//   drawn per run. The observed outputs are compressed into segments of
//   identical output pattern; the expected segment list is built from the
//   phase rules (clear, grant per core, gap, compute, grant per core, done or
//   error) and the per-core latencies.

module tb_bcrypt_core_sched;

  localparam int NC    = 2;
  localparam int SW    = 4;
  localparam int CLR   = 4;
  localparam int TO    = 100;
  localparam int NEVER = 100000;
  localparam int SIGW  = 32*NC + SW + 4;

  typedef struct {
    logic [SIGW-1:0] sig;
    int              len;
  } seg_t;

  logic             clk;
  logic             rst;
  logic             go;
  logic             busy;
  logic             finished;
  logic             error;
  logic [SW-1:0]    err_core;
  logic [32*NC-1:0] core_start;
  logic [32*NC-1:0] core_done;
  logic             grant_valid;
  logic [SW-1:0]    grant_sel;

  int n_cmp = 0;
  int n_mis = 0;

  int lat_ld [NC];
  int lat_cp [NC];
  int lat_st [NC];
  int seen_code [NC];
  int seen_cnt  [NC];

  seg_t            obs_q[$];
  seg_t            exp_q[$];
  logic [SIGW-1:0] seg_sig;
  int              seg_len;
  bit              seg_valid = 1'b0;
  logic            prev_gv   = 1'b0;
  logic [SW-1:0]   prev_sel  = {SW{1'b0}};
  int              err_exp;

  bcrypt_core_sched #(
    .NUM_CORES  (NC),
    .SEL_W      (SW),
    .CLR_CYCLES (CLR),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .busy        (busy),
    .finished    (finished),
    .error       (error),
    .err_core    (err_core),
    .core_start  (core_start),
    .core_done   (core_done),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  initial clk = 1'b0;
  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core i gets lo when i <= k, hi otherwise.
  function automatic logic [32*NC-1:0] codes(input int k, input logic [31:0] lo, input logic [31:0] hi);
    logic [32*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[32*i +: 32] = (i <= k) ? lo : hi;
    return v;
  endfunction

  function automatic logic [SIGW-1:0] mk_sig(input logic [32*NC-1:0] st, input logic gv,
                                             input logic [SW-1:0] sel, input logic b,
                                             input logic f, input logic e);
    return {st, gv, sel, b, f, e};
  endfunction

  task automatic push_exp(input logic [SIGW-1:0] s, input int len);
    seg_t t;
    t.sig = s;
    t.len = len;
    exp_q.push_back(t);
  endtask

  // Expected segment list for one run from the current latencies.
  task automatic build_exp();
    logic [SIGW-1:0] err_sig;
    int mx;
    int lowest;
    err_sig = mk_sig(codes(NC-1, 32'd0, 32'd0), 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    exp_q.delete();
    err_exp = -1;
    push_exp(mk_sig(codes(NC-1, 32'd0, 32'd0), 1'b0, 4'd0, 1'b1, 1'b0, 1'b0), CLR);
    for (int k = 0; k < NC; k++) begin
      if (lat_ld[k] + 1 > TO) begin
        push_exp(mk_sig(codes(k, 32'd1, 32'd0), 1'b1, SW'(k), 1'b1, 1'b0, 1'b0), TO);
        push_exp(err_sig, 0);
        err_exp = k;
        return;
      end
      push_exp(mk_sig(codes(k, 32'd1, 32'd0), 1'b1, SW'(k), 1'b1, 1'b0, 1'b0), lat_ld[k] + 1);
      push_exp(mk_sig(codes(k, 32'd1, 32'd0), 1'b0, 4'd0, 1'b1, 1'b0, 1'b0), 1);
    end
    mx = 0;
    lowest = -1;
    for (int k = 0; k < NC; k++) begin
      if (lat_cp[k] > mx) mx = lat_cp[k];
      if ((lat_cp[k] + 1 > TO) && (lowest < 0)) lowest = k;
    end
    if (lowest >= 0) begin
      push_exp(mk_sig(codes(NC-1, 32'd2, 32'd2), 1'b0, 4'd0, 1'b1, 1'b0, 1'b0), TO);
      push_exp(err_sig, 0);
      err_exp = lowest;
      return;
    end
    push_exp(mk_sig(codes(NC-1, 32'd2, 32'd2), 1'b0, 4'd0, 1'b1, 1'b0, 1'b0), mx + 1);
    for (int k = 0; k < NC; k++) begin
      if (lat_st[k] + 1 > TO) begin
        push_exp(mk_sig(codes(k, 32'd3, 32'd2), 1'b1, SW'(k), 1'b1, 1'b0, 1'b0), TO);
        push_exp(err_sig, 0);
        err_exp = k;
        return;
      end
      push_exp(mk_sig(codes(k, 32'd3, 32'd2), 1'b1, SW'(k), 1'b1, 1'b0, 1'b0), lat_st[k] + 1);
      push_exp(mk_sig(codes(k, 32'd3, 32'd2), 1'b0, 4'd0, 1'b1, 1'b0, 1'b0), 1);
    end
    push_exp(mk_sig(codes(NC-1, 32'd3, 32'd3), 1'b0, 4'd0, 1'b0, 1'b1, 1'b0), 0);
  endtask

  // Segment recorder plus per-cycle grant rules.
  task automatic monitor_step();
    logic [SIGW-1:0] s;
    seg_t t;
    s = {core_start, grant_valid, (grant_valid ? grant_sel : {SW{1'b0}}), busy, finished, error};
    if (prev_gv && grant_valid) check_val("grant_sel_stable", grant_sel, prev_sel);
    if (grant_valid) check_val("grant_sel_range", (grant_sel < NC), 1'b1);
    prev_gv  = grant_valid;
    prev_sel = grant_sel;
    if (!seg_valid) begin
      seg_sig   = s;
      seg_len   = 1;
      seg_valid = 1'b1;
    end else if (s == seg_sig) begin
      seg_len++;
    end else begin
      t.sig = seg_sig;
      t.len = seg_len;
      obs_q.push_back(t);
      seg_sig = s;
      seg_len = 1;
    end
  endtask

  // Behavioural cores: answer a start code after its latency, clear on code 0.
  task automatic core_step();
    logic [31:0] code;
    for (int i = 0; i < NC; i++) begin
      code = core_start[32*i +: 32];
      if (int'(code) != seen_code[i]) begin
        seen_code[i] = int'(code);
        seen_cnt[i]  = 0;
      end
      seen_cnt[i]++;
      case (code)
        32'd0: core_done[32*i +: 32] = 32'd0;
        32'd1: if (seen_cnt[i] >= lat_ld[i]) core_done[32*i +: 32] = 32'd1;
        32'd2: if (seen_cnt[i] >= lat_cp[i]) core_done[32*i +: 32] = 32'd2;
        32'd3: if (seen_cnt[i] >= lat_st[i]) core_done[32*i +: 32] = 32'h0000_00FF;
        default: core_done[32*i +: 32] = core_done[32*i +: 32];
      endcase
    end
  endtask

  initial begin
    core_done = {(32*NC){1'b0}};
    forever begin
      @(negedge clk);
      monitor_step();
      core_step();
    end
  end

  task automatic do_run(input int again);
    int cyc;
    build_exp();
    @(posedge clk); #1;
    obs_q.delete();
    seg_valid = 1'b0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check_val("busy_after_go", busy, 1'b1);
    cyc = 0;
    while (busy && cyc < 3000) begin
      go = (cyc == again);
      @(posedge clk); #1;
      cyc++;
    end
    go = 1'b0;
    check_val("run_ends", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_val("nseg", obs_q.size(), exp_q.size());
    for (int j = 0; j + 1 < exp_q.size(); j++) begin
      if (j + 1 < obs_q.size()) begin
        check_val($sformatf("seg%0d_sig", j), obs_q[j+1].sig, exp_q[j].sig);
        check_val($sformatf("seg%0d_len", j), obs_q[j+1].len, exp_q[j].len);
      end
    end
    check_val("final_sig", seg_sig, exp_q[exp_q.size()-1].sig);
    if (err_exp >= 0) check_val("err_core", err_core, err_exp);
  endtask

  task automatic set_lat(input int l0, input int l1, input int c0, input int c1,
                         input int s0, input int s1);
    lat_ld[0] = l0; lat_ld[1] = l1;
    lat_cp[0] = c0; lat_cp[1] = c1;
    lat_st[0] = s0; lat_st[1] = s1;
  endtask

  task automatic random_run();
    set_lat($urandom_range(1, 60), $urandom_range(1, 60), $urandom_range(1, 60),
            $urandom_range(1, 60), $urandom_range(1, 60), $urandom_range(1, 60));
    do_run($urandom_range(1, 10));
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_start"}, core_start, {(32*NC){1'b0}});
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_gv"}, grant_valid, 1'b0);
    check_val({tag, "_gsel"}, grant_sel, {SW{1'b0}});
    check_val({tag, "_fin"}, finished, 1'b0);
    check_val({tag, "_err"}, error, 1'b0);
    check_val({tag, "_errcore"}, err_core, {SW{1'b0}});
  endtask

  task automatic mid_reset();
    int cyc;
    set_lat(5, 5, 80, 80, 5, 5);
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    cyc = 0;
    while ((core_start != codes(NC-1, 32'd2, 32'd2)) && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("reach_compute", core_start, codes(NC-1, 32'd2, 32'd2));
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    set_lat(1, 1, 1, 1, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    // Reference run: load 10, compute 50, store 20, with a go while busy.
    set_lat(10, 10, 50, 50, 20, 20);
    do_run(15);
    for (int r = 0; r < 4; r++) random_run();
    // Answers on the last watchdog cycle must still be accepted.
    set_lat(5, TO - 1, TO - 1, 20, TO - 1, 3);
    do_run(-1);
    // Core 1 never computes.
    set_lat(3, 7, 40, NEVER, 5, 5);
    do_run(-1);
    random_run();
    // Core 0 never stores.
    set_lat(4, 4, 10, 12, NEVER, 10);
    do_run(-1);
    // Core 1 answers the load one cycle too late.
    set_lat(3, TO, 10, 10, 10, 10);
    do_run(-1);
    random_run();
    mid_reset();
    random_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
